// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared encodings for the processor datapath and control FSM
package proc_pkg;

    // Bus source codes (read_en). Codes 0, 11, 14 and 15 drive zero.
    localparam logic [3:0] RD_NONE = 4'd0;
    localparam logic [3:0] RD_PC   = 4'd1;
    localparam logic [3:0] RD_AR   = 4'd2;
    localparam logic [3:0] RD_DR   = 4'd3;
    localparam logic [3:0] RD_IR   = 4'd4;
    localparam logic [3:0] RD_AC   = 4'd5;
    localparam logic [3:0] RD_R    = 4'd6;
    localparam logic [3:0] RD_R1   = 4'd7;
    localparam logic [3:0] RD_R2   = 4'd8;
    localparam logic [3:0] RD_R3   = 4'd9;
    localparam logic [3:0] RD_R4   = 4'd10;
    localparam logic [3:0] RD_DM   = 4'd12;
    localparam logic [3:0] RD_IM   = 4'd13;

    // Destination bit indices within write_en.
    localparam int WR_PC  = 1;
    localparam int WR_AR  = 2;
    localparam int WR_IR  = 3;
    localparam int WR_AC  = 4;
    localparam int WR_R   = 5;
    localparam int WR_R4  = 7;
    localparam int WR_R3  = 8;
    localparam int WR_R2  = 9;
    localparam int WR_R1  = 10;
    localparam int WR_DM  = 11;
    localparam int WR_ALU = 12;

    // Increment / clear bit indices.
    localparam int INC_PC = 1;
    localparam int INC_AC = 4;
    localparam int CLR_AC = 4;

    // ALU operation codes; 5-7 fall back to pass.
    localparam logic [2:0] ALU_PASS   = 3'd0;
    localparam logic [2:0] ALU_ADD    = 3'd1;
    localparam logic [2:0] ALU_SUB    = 3'd2;
    localparam logic [2:0] ALU_MULT   = 3'd3;
    localparam logic [2:0] ALU_LSHIFT = 3'd4;

endpackage

// File: rtl/proc_alu.sv
// rtl/proc_alu.sv - combinational ALU (pass/add/sub/mult/lshift), result truncated to DATA_W
// Ports: op (operation code), a (AC), b (R), result.
module proc_alu
    import proc_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result
);

    always_comb begin
        result = a;
        case (op)
            ALU_ADD:    result = a + b;
            ALU_SUB:    result = a - b;
            ALU_MULT:   result = a * b;   // low DATA_W bits of the product
            ALU_LSHIFT: result = {a[DATA_W-2:0], 1'b0};
            default:    result = a;
        endcase
    end

endmodule

// File: rtl/proc_datapath.sv
// rtl/proc_datapath.sv - single-bus register datapath driven by the processor control FSM
// Ports: clk/rst; read_en selects the bus source, write_en/inc_en/clr_en load, bump or clear
// registers, alu_op picks the ALU function; instruction/z go back to the control FSM;
// im_* and dm_* are the instruction/data memory ports; ac_out exposes AC.
module proc_datapath
    import proc_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        read_en,
    input  logic [15:0]       write_en,
    input  logic [15:0]       inc_en,
    input  logic [15:0]       clr_en,
    input  logic [2:0]        alu_op,
    output logic [5:0]        instruction,
    output logic [15:0]       z,
    output logic [ADDR_W-1:0] im_addr,
    input  logic [DATA_W-1:0] im_rdata,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    output logic              dm_we,
    input  logic [DATA_W-1:0] dm_rdata,
    output logic [DATA_W-1:0] ac_out
);

    logic [ADDR_W-1:0] pc_q, pc_d, ar_q, ar_d;
    logic [DATA_W-1:0] dr_q, ir_q, ir_d, ac_q, ac_d, r_q, r_d;
    logic [DATA_W-1:0] r1_q, r1_d, r2_q, r2_d, r3_q, r3_d, r4_q, r4_d;
    logic [DATA_W-1:0] bus, alu_result;

    // Enable bits with no destination in this datapath.
    logic unused_en;
    assign unused_en = ^{write_en[15:13], write_en[6], write_en[0],
                         inc_en[15:5], inc_en[3:2], inc_en[0],
                         clr_en[15:5], clr_en[3:0]};

    // Bus source mux; reads see register values from before this cycle's edge.
    always_comb begin
        bus = '0;
        case (read_en)
            RD_PC: bus = {{(DATA_W-ADDR_W){1'b0}}, pc_q};
            RD_AR: bus = {{(DATA_W-ADDR_W){1'b0}}, ar_q};
            RD_DR: bus = dr_q;
            RD_IR: bus = {6'b0, ir_q[DATA_W-1:6]};
            RD_AC: bus = ac_q;
            RD_R:  bus = r_q;
            RD_R1: bus = r1_q;
            RD_R2: bus = r2_q;
            RD_R3: bus = r3_q;
            RD_R4: bus = r4_q;
            RD_DM: bus = dm_rdata;
            RD_IM: bus = im_rdata;
            default: bus = '0;
        endcase
    end

    proc_alu #(.DATA_W(DATA_W)) u_alu (
        .op     (alu_op),
        .a      (ac_q),
        .b      (r_q),
        .result (alu_result)
    );

    always_comb begin
        pc_d = pc_q;
        if (write_en[WR_PC])      pc_d = bus[ADDR_W-1:0];
        else if (inc_en[INC_PC])  pc_d = pc_q + 1'b1;

        ar_d = write_en[WR_AR] ? bus[ADDR_W-1:0] : ar_q;
        ir_d = write_en[WR_IR] ? bus : ir_q;
        r_d  = write_en[WR_R]  ? bus : r_q;
        r1_d = write_en[WR_R1] ? bus : r1_q;
        r2_d = write_en[WR_R2] ? bus : r2_q;
        r3_d = write_en[WR_R3] ? bus : r3_q;
        r4_d = write_en[WR_R4] ? bus : r4_q;

        // Clear beats any load; the ALU result beats a plain bus load.
        ac_d = ac_q;
        if (clr_en[CLR_AC])       ac_d = '0;
        else if (write_en[WR_ALU]) ac_d = alu_result;
        else if (write_en[WR_AC])  ac_d = bus;
        else if (inc_en[INC_AC])   ac_d = ac_q + 1'b1;
    end

    // DR has no load path in this datapath; it only ever holds its reset value.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= '0; ar_q <= '0; dr_q <= '0; ir_q <= '0;
            ac_q <= '0; r_q  <= '0;
            r1_q <= '0; r2_q <= '0; r3_q <= '0; r4_q <= '0;
        end else begin
            pc_q <= pc_d; ar_q <= ar_d; dr_q <= dr_q; ir_q <= ir_d;
            ac_q <= ac_d; r_q  <= r_d;
            r1_q <= r1_d; r2_q <= r2_d; r3_q <= r3_d; r4_q <= r4_d;
        end
    end

    assign instruction = ir_q[5:0];
    assign z           = {15'b0, (ac_q == '0)};
    assign im_addr     = pc_q;
    assign dm_addr     = ar_q;
    assign dm_wdata    = bus;
    assign dm_we       = write_en[WR_DM];
    assign ac_out      = ac_q;

endmodule

// File: tb/tb_proc_datapath.sv
// tb/tb_proc_datapath.sv - scoreboard bench for proc_datapath with reference model
module tb_proc_datapath;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  read_en = '0;
    logic [15:0] write_en = '0, inc_en = '0, clr_en = '0;
    logic [2:0]  alu_op = '0;
    logic [5:0]  instruction;
    logic [15:0] z;
    logic [9:0]  im_addr, dm_addr;
    logic [15:0] im_rdata = '0, dm_rdata = '0, dm_wdata, ac_out;
    logic        dm_we;

    proc_datapath #(.DATA_W(16), .ADDR_W(10)) dut (
        .clk(clk), .rst(rst), .read_en(read_en), .write_en(write_en),
        .inc_en(inc_en), .clr_en(clr_en), .alu_op(alu_op),
        .instruction(instruction), .z(z), .im_addr(im_addr), .im_rdata(im_rdata),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_we(dm_we), .dm_rdata(dm_rdata),
        .ac_out(ac_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned instr, zf, ima, dma, we, wdata, ac, cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    // Reference model state: registers as plain integers.
    int unsigned m_pc = 0, m_ar = 0, m_dr = 0, m_ir = 0, m_ac = 0, m_r = 0;
    int unsigned m_rn[4] = '{0, 0, 0, 0};   // R1..R4

    function automatic int unsigned bit_of(int unsigned v, int b);
        return (v >> b) & 1;
    endfunction

    function automatic int unsigned m_bus(int unsigned rd, int unsigned im, int unsigned dm);
        case (rd)
            1:  return m_pc;
            2:  return m_ar;
            3:  return m_dr;
            4:  return m_ir / 64;
            5:  return m_ac;
            6:  return m_r;
            7, 8, 9, 10: return m_rn[rd - 7];
            12: return dm;
            13: return im;
            default: return 0;
        endcase
    endfunction

    function automatic int unsigned m_alu(int unsigned op);
        case (op)
            1: return (m_ac + m_r) % 65536;
            2: return (m_ac + 65536 - m_r) % 65536;
            3: return (m_ac * m_r) % 65536;
            4: return (m_ac * 2) % 65536;
            default: return m_ac;
        endcase
    endfunction

    task automatic drive(input int unsigned rd, input int unsigned we, input int unsigned inc,
                         input int unsigned clr, input int unsigned op, input int unsigned im,
                         input int unsigned dm, input bit r);
        exp_t e;
        int unsigned b, alu, n_pc, n_ac;
        @(posedge clk);
        #1;
        rst = r; read_en = rd[3:0]; write_en = we[15:0]; inc_en = inc[15:0];
        clr_en = clr[15:0]; alu_op = op[2:0]; im_rdata = im[15:0]; dm_rdata = dm[15:0];
        cyc++;
        b   = m_bus(rd, im, dm);
        alu = m_alu(op);
        e.instr = m_ir % 64;  e.zf = (m_ac == 0) ? 1 : 0;
        e.ima = m_pc;  e.dma = m_ar;  e.we = bit_of(we, 11);
        e.wdata = b;   e.ac = m_ac;   e.cyc = cyc;
        sb.push_back(e);
        if (r) begin
            m_pc = 0; m_ar = 0; m_dr = 0; m_ir = 0; m_ac = 0; m_r = 0;
            m_rn = '{0, 0, 0, 0};
        end else begin
            n_pc = m_pc;
            if (bit_of(we, 1))       n_pc = b % 1024;
            else if (bit_of(inc, 1)) n_pc = (m_pc + 1) % 1024;
            n_ac = m_ac;
            if (bit_of(clr, 4))       n_ac = 0;
            else if (bit_of(we, 12))  n_ac = alu;
            else if (bit_of(we, 4))   n_ac = b;
            else if (bit_of(inc, 4))  n_ac = (m_ac + 1) % 65536;
            m_pc = n_pc;  m_ac = n_ac;
            if (bit_of(we, 2))  m_ar = b % 1024;
            if (bit_of(we, 3))  m_ir = b;
            if (bit_of(we, 5))  m_r = b;
            if (bit_of(we, 10)) m_rn[0] = b;
            if (bit_of(we, 9))  m_rn[1] = b;
            if (bit_of(we, 8))  m_rn[2] = b;
            if (bit_of(we, 7))  m_rn[3] = b;
        end
    endtask

    task automatic idle(input int unsigned rd);
        drive(rd, 0, 0, 0, 0, 0, 0, 1'b0);
    endtask

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: the DUT presents a full output set every cycle; compare mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_cmp++;
                if (instruction != e.instr[5:0] || z != e.zf[15:0] || im_addr != e.ima[9:0] ||
                    dm_addr != e.dma[9:0] || dm_we != e.we[0] || dm_wdata != e.wdata[15:0] ||
                    ac_out != e.ac[15:0]) begin
                    n_err++;
                    $display("FAIL scoreboard cyc %0d: got ins=%0h z=%0h im=%0h dm=%0h we=%0b wd=%0h ac=%0h expected ins=%0h z=%0h im=%0h dm=%0h we=%0b wd=%0h ac=%0h",
                             e.cyc, instruction, z, im_addr, dm_addr, dm_we, dm_wdata, ac_out,
                             e.instr, e.zf, e.ima, e.dma, e.we, e.wdata, e.ac);
                end
            end
        end
    end

    initial begin
        // Reset held two cycles with random enables.
        repeat (2) drive($urandom_range(0, 15), $urandom, $urandom, $urandom,
                         $urandom_range(0, 7), $urandom, $urandom, 1'b1);
        @(negedge clk);
        chk("rst_ac", ac_out, 0);
        chk("rst_z", z, 16'h0001);
        chk("rst_im_addr", im_addr, 0);
        chk("rst_instr", instruction, 0);
        idle(0);
        @(negedge clk);
        chk("post_rst_ac", ac_out, 0);
        chk("post_rst_dm_addr", dm_addr, 0);

        // Fetch.
        drive(13, 1 << 1, 0, 0, 0, 5, 0, 1'b0);
        drive(13, 1 << 3, 0, 0, 0, 16'h0A43, 0, 1'b0);
        idle(4);
        @(negedge clk);
        chk("fetch_instr", instruction, 6'h03);
        chk("fetch_operand", dm_wdata, 16'h0029);
        chk("fetch_pc", im_addr, 5);

        // Load/store.
        drive(13, 1 << 2, 0, 0, 0, 7, 0, 1'b0);
        drive(12, 1 << 4, 1 << 1, 0, 0, 0, 16'h1234, 1'b0);
        drive(5, 1 << 11, 0, 0, 0, 0, 0, 1'b0);
        @(negedge clk);
        chk("store_we", dm_we, 1);
        chk("store_addr", dm_addr, 7);
        chk("store_wdata", dm_wdata, 16'h1234);
        chk("load_pc_inc", im_addr, 6);

        // ALU: add wrap, sub to zero, mult overflow, lshift.
        drive(13, 1 << 4, 0, 0, 0, 16'hFFFF, 0, 1'b0);
        drive(13, 1 << 5, 0, 0, 0, 2, 0, 1'b0);
        drive(0, 1 << 12, 0, 0, 1, 0, 0, 1'b0);
        idle(0); @(negedge clk);
        chk("add_ac", ac_out, 1);
        chk("add_z", z, 0);
        drive(13, (1 << 4) | (1 << 5), 0, 0, 0, 3, 0, 1'b0);
        drive(0, 1 << 12, 0, 0, 2, 0, 0, 1'b0);
        idle(0); @(negedge clk);
        chk("sub_ac", ac_out, 0);
        chk("sub_z", z, 1);
        drive(13, (1 << 4) | (1 << 5), 0, 0, 0, 16'h0100, 0, 1'b0);
        drive(0, 1 << 12, 0, 0, 3, 0, 0, 1'b0);
        idle(0); @(negedge clk);
        chk("mult_ac", ac_out, 0);
        drive(13, 1 << 4, 0, 0, 0, 16'h8001, 0, 1'b0);
        drive(0, 1 << 12, 0, 0, 4, 0, 0, 1'b0);
        idle(0); @(negedge clk);
        chk("lshift_ac", ac_out, 16'h0002);

        // Priority and wrap.
        drive(13, 1 << 4, 1 << 4, 1 << 4, 0, 16'h0077, 0, 1'b0);
        idle(0); @(negedge clk);
        chk("clr_priority", ac_out, 0);
        drive(13, 1 << 1, 0, 0, 0, 1023, 0, 1'b0);
        drive(0, 0, 1 << 1, 0, 0, 0, 0, 1'b0);
        idle(0); @(negedge clk);
        chk("pc_wrap", im_addr, 0);
        drive(13, 1 << 3, 0, 0, 0, 12 << 6, 0, 1'b0);
        drive(4, 1 << 1, 1 << 1, 0, 0, 0, 0, 1'b0);
        idle(0); @(negedge clk);
        chk("pc_write_over_inc", im_addr, 12);

        // Register moves and the unused source code.
        drive(13, 1 << 4, 0, 0, 0, 9, 0, 1'b0);
        drive(5, 16'h0780, 0, 0, 0, 0, 0, 1'b0);
        for (int k = 7; k <= 10; k++) begin
            idle(k); @(negedge clk);
            chk($sformatf("rn_move_%0d", k), dm_wdata, 9);
        end
        drive(0, 0, 0, 1 << 4, 0, 0, 0, 1'b0);
        drive(8, 1 << 4, 0, 0, 0, 0, 0, 1'b0);
        idle(11); @(negedge clk);
        chk("ac_from_r2", ac_out, 9);
        chk("unused_src", dm_wdata, 0);

        // Randomized traffic; clears and resets kept rare so state can build up.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 15), $urandom & 16'hFFFF, $urandom & 16'hFFFF,
                  $urandom & (($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'hFFEF),
                  $urandom_range(0, 7), $urandom & 16'hFFFF, $urandom & 16'hFFFF,
                  ($urandom_range(0, 63) == 0));
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
